// File: rtl/sm_reg_scanner_pkg.sv
// Shared definitions for the CPU debug register scanner.
// Holds the FSM state encoding, the frame length in bytes and the debug-port
// address width used by sm_reg_scanner and sm_frame_serializer.
package sm_reg_scanner_pkg;

   localparam int unsigned FRAME_BYTES = 5;
   localparam int unsigned REG_ADDR_W  = 5;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SEND   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/sm_frame_serializer.sv
// Frame serializer for the register scanner.
// Loads {addr, data} as one frame and presents it MSB-first, one byte at a time,
// on a valid/ready interface. Reports the cycle in which the final byte is taken.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   load         capture loadAddr/loadData and start presenting byte 0
//   loadAddr     register address, becomes byte 0 (zero-extended to 8 bits)
//   loadData     register value, becomes bytes 1..4 (MSB first)
//   out_valid    out_data holds a valid byte
//   out_ready    downstream accepts the byte when out_valid & out_ready
//   out_data     current frame byte
//   lastAccepted the final frame byte is accepted this cycle
module sm_frame_serializer
   import sm_reg_scanner_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [REG_ADDR_W-1:0] loadAddr,
   input  logic [31:0]           loadData,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [7:0]            out_data,
   output logic                  lastAccepted
);

   localparam int unsigned FRAME_W  = 8 * FRAME_BYTES;
   localparam logic [2:0]  LAST_IDX = 3'(FRAME_BYTES - 1);

   logic [FRAME_W-1:0] frameQ;
   logic [2:0]         byteIdxQ;
   logic               validQ;
   logic               accept;

   assign accept       = validQ & out_ready;
   assign lastAccepted = accept && (byteIdxQ == LAST_IDX);
   assign out_valid    = validQ;
   // The presented byte is always the top of the shift register, so it cannot
   // change while the byte is waiting to be accepted.
   assign out_data     = frameQ[FRAME_W-1 -: 8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frameQ   <= '0;
         byteIdxQ <= '0;
         validQ   <= 1'b0;
      end else if (load) begin
         frameQ   <= {{(8 - REG_ADDR_W){1'b0}}, loadAddr, loadData};
         byteIdxQ <= '0;
         validQ   <= 1'b1;
      end else if (accept) begin
         frameQ <= {frameQ[FRAME_W-9:0], 8'h00};
         if (byteIdxQ == LAST_IDX) begin
            byteIdxQ <= '0;
            validQ   <= 1'b0;
         end else begin
            byteIdxQ <= byteIdxQ + 3'd1;
         end
      end
   end

endmodule

// File: rtl/sm_reg_scanner.sv
// Host-side reader for the CPU debug register port.
// On a start pulse, walks regAddr 0..NREGS-1, holds each address for SETTLE
// cycles (input synchroniser plus divided CPU clock), captures regData and
// streams a 5-byte frame {addr, data[31:24..7:0]} per register.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-high
//   start     scan request pulse, honoured only when idle
//   busy      scan in progress (SETTLE/SEND/DONE)
//   done      one-cycle pulse after the last frame byte is accepted
//   regAddr   address driven to the CPU debug port
//   regData   value returned by the CPU debug port
//   out_valid out_data holds a valid byte
//   out_ready downstream accepts the byte when out_valid & out_ready
//   out_data  frame byte
module sm_reg_scanner
   import sm_reg_scanner_pkg::*;
#(
   parameter int unsigned NREGS  = 32,
   parameter int unsigned SETTLE = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [REG_ADDR_W-1:0] regAddr,
   input  logic [31:0]           regData,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [7:0]            out_data
);

   localparam int unsigned          CNT_W       = $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE - 1);
   localparam logic [REG_ADDR_W-1:0] LAST_ADDR  = REG_ADDR_W'(NREGS - 1);

   state_t                  stateQ, stateD;
   logic [REG_ADDR_W-1:0]   regAddrQ, regAddrD;
   logic [CNT_W-1:0]        cntQ, cntD;
   logic                    capture;
   logic                    lastAccepted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ   <= S_IDLE;
         regAddrQ <= '0;
         cntQ     <= '0;
      end else begin
         stateQ   <= stateD;
         regAddrQ <= regAddrD;
         cntQ     <= cntD;
      end
   end

   always_comb begin
      stateD   = stateQ;
      regAddrD = regAddrQ;
      cntD     = cntQ;
      capture  = 1'b0;
      unique case (stateQ)
         S_IDLE: begin
            if (start) begin
               stateD   = S_SETTLE;
               regAddrD = '0;
               cntD     = '0;
            end
         end
         S_SETTLE: begin
            // regData is sampled only here; later changes cannot reach the frame.
            if (cntQ == SETTLE_LAST) begin
               capture = 1'b1;
               stateD  = S_SEND;
            end else begin
               cntD = cntQ + 1'b1;
            end
         end
         S_SEND: begin
            if (lastAccepted) begin
               if (regAddrQ == LAST_ADDR) begin
                  stateD = S_DONE;
               end else begin
                  stateD   = S_SETTLE;
                  regAddrD = regAddrQ + 5'd1;
                  cntD     = '0;
               end
            end
         end
         S_DONE: begin
            // start is deliberately not looked at here.
            stateD   = S_IDLE;
            regAddrD = '0;
            cntD     = '0;
         end
         default: stateD = S_IDLE;
      endcase
   end

   assign busy    = (stateQ != S_IDLE);
   assign done    = (stateQ == S_DONE);
   assign regAddr = regAddrQ;

   sm_frame_serializer u_serializer (
      .clk          (clk),
      .rst          (rst),
      .load         (capture),
      .loadAddr     (regAddrQ),
      .loadData     (regData),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .lastAccepted (lastAccepted)
   );

endmodule
